// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Inter-stage pipeline register (IF/ID, ID/EX, ...) with a valid/ready
//   handshake. It holds two entries: the main output register and a skid
//   buffer. The skid buffer catches the instruction that arrives in the same
//   cycle that downstream stalls, so backpressure never drops an instruction.
//   With no stall, the stage moves one instruction per cycle.
//   flush_i squashes both entries and leaves a bubble (NOP_INSTR) on the
//   output. The PC of the squashing cycle is kept on addr_o for debug.
//
// Optional feature (macro PIPE_STAGE_STATS_EN):
//   stall_cnt_o / flush_cnt_o are saturating event counters, CNT_W bits wide.
//   Without the macro these ports and counters do not exist.
//
// Ports
//   clk_i        in   1       clock, posedge
//   rst_i        in   1       synchronous reset, active-high
//   flush_i      in   1       squash both entries, inject bubble
//   in_valid_i   in   1       upstream offers an instruction
//   in_ready_o   out  1       stage accepts this cycle (registered)
//   addr_i       in   ADDR_W  upstream address
//   instr_i      in   DATA_W  upstream instruction
//   out_valid_o  out  1       addr_o/instr_o carry a valid instruction
//   out_ready_i  in   1       downstream consumes this cycle
//   addr_o       out  ADDR_W  address to downstream
//   instr_o      out  DATA_W  instruction to downstream
//   count_o      out  2       occupancy 0..2
//   stall_cnt_o  out  CNT_W  cycles with out_valid_o & !out_ready_i (stats only)
//   flush_cnt_o  out  CNT_W  cycles with flush_i (stats only)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [1:0]        count_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  localparam int unsigned OCC_W = 2;

  // Elaboration guard against degenerate widths.
  if (ADDR_W == 0 || DATA_W == 0 || CNT_W == 0) begin : g_bad_param
    $error("pipe_stage_skid: ADDR_W, DATA_W and CNT_W must be non-zero");
  end

  // One pipeline entry: address plus instruction payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr;
  } entry_t;

  // Occupancy states; the encoding is {skid valid, main valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  entry_t            main_q,  main_d;
  entry_t            skid_q,  skid_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;
  logic [OCC_W-1:0]  count_q,     count_d;

  logic              accept_c;
  logic              pop_c;
  entry_t            in_entry_c;

  // Handshake events for this cycle.
  assign accept_c   = in_valid_i & in_ready_q;
  assign pop_c      = out_valid_q & out_ready_i;
  assign in_entry_c = '{addr: addr_i, instr: instr_i};

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_q      <= '{addr: '0, instr: NOP_INSTR};
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      count_q     <= count_d;
    end
  end

  // Next-state, datapath steering and registered-output precompute.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_ONE;
          main_d  = in_entry_c;
        end
      end
      ST_ONE: begin
        if (accept_c && pop_c) begin
          main_d  = in_entry_c;
        end else if (accept_c) begin
          // Downstream stalled as the new instruction arrived: park it.
          state_d = ST_FULL;
          skid_d  = in_entry_c;
        end else if (pop_c) begin
          // Going empty: payload stays on the outputs, only valid drops.
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush overrides everything. Any same-cycle accept is dropped, and the
    // current PC is kept on addr_o for debug.
    if (flush_i) begin
      state_d      = ST_EMPTY;
      main_d.addr  = addr_i;
      main_d.instr = NOP_INSTR;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    case (state_d)
      ST_FULL: count_d = OCC_W'(2);
      ST_ONE:  count_d = OCC_W'(1);
      default: count_d = OCC_W'(0);
    endcase
  end

  assign out_valid_o = out_valid_q;
  assign in_ready_o  = in_ready_q;
  assign addr_o      = main_q.addr;
  assign instr_o     = main_q.instr;
  assign count_o     = count_q;

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating stall / flush event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready_i && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_i && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
